// File: rtl/output_fm_pkg.sv
// output_fm_pkg: shared FSM state type and bank-index width helper for output_fm_multibank
package output_fm_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, STORE, DRAIN} state_t;
  function automatic int bank_w(input int y);
    return (y > 1) ? $clog2(y) : 1;
  endfunction
  localparam int BANK_W = bank_w(4);
endpackage

// File: rtl/output_fm_multibank_if.sv
// output_fm_multibank_if: control, FIFO and bank buses of output_fm_multibank
// master: the engine (drives busy/done, FIFO pop/push, bank strobes); slave: its environment
interface output_fm_multibank_if #(parameter int AW = 16, parameter int DW = 32, parameter int Y = 4);
  logic ld_start, st_start, zero_init, busy, ld_done, st_done;
  logic [DW-1:0] ld_fifo_data;
  logic ld_fifo_empty, ld_fifo_pop;
  logic [DW-1:0] st_fifo_data;
  logic st_fifo_push, st_fifo_almost_full;
  logic [Y-1:0] bank_wr_ena;
  logic [AW-1:0] bank_wr_addr;
  logic [DW-1:0] bank_wr_data;
  logic [Y-1:0] bank_rd_ena;
  logic [AW-1:0] bank_rd_addr;
  logic [Y*DW-1:0] bank_rd_data;
  modport master(
    input ld_start, st_start, zero_init, ld_fifo_data, ld_fifo_empty, st_fifo_almost_full, bank_rd_data,
    output busy, ld_done, st_done, ld_fifo_pop, st_fifo_data, st_fifo_push,
    bank_wr_ena, bank_wr_addr, bank_wr_data, bank_rd_ena, bank_rd_addr
  );
  modport slave(
    output ld_start, st_start, zero_init, ld_fifo_data, ld_fifo_empty, st_fifo_almost_full, bank_rd_data,
    input busy, ld_done, st_done, ld_fifo_pop, st_fifo_data, st_fifo_push,
    bank_wr_ena, bank_wr_addr, bank_wr_data, bank_rd_ena, bank_rd_addr
  );
endinterface

// File: rtl/out_fm_rd_pipe.sv
// out_fm_rd_pipe: RD_LAT-deep delay line carrying read-valid and bank index
// ports: clk, rst (async high); vld_i/bank_i issued read; vld_o/bank_o same read RD_LAT cycles later;
// inflight high while any read is still travelling through the line
module out_fm_rd_pipe #(
  parameter int RD_LAT = 2,
  parameter int BW = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          vld_i,
  input  logic [BW-1:0] bank_i,
  output logic          vld_o,
  output logic [BW-1:0] bank_o,
  output logic          inflight
);
  localparam int PW = RD_LAT * BW;
  logic [RD_LAT-1:0] vld_q, vld_d;
  logic [PW-1:0] bank_q, bank_d;
  always_comb begin
    vld_d = RD_LAT'({vld_q, vld_i});
    bank_d = PW'({bank_q, bank_i});
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      vld_q <= '0;
      bank_q <= '0;
    end else begin
      vld_q <= vld_d;
      bank_q <= bank_d;
    end
  assign vld_o = vld_q[RD_LAT-1];
  assign bank_o = bank_q[PW-1 -: BW];
  assign inflight = |vld_q;
endmodule

// File: rtl/output_fm_multibank.sv
// output_fm_multibank: loads Y*SLICE words from a FIFO into Y banks and stores them back to a FIFO
// ports: clk, rst (async high); bus (master): ld_start/st_start/zero_init control, busy/ld_done/st_done status,
// load FIFO (data/empty/pop), store FIFO (data/push/almost_full), bank write and read strobes/address/data
// OUTPUT_FM_ZERO_INIT_EN: when defined, ld_start with zero_init fills every bank with zeros instead of the FIFO
module output_fm_multibank
  import output_fm_pkg::*;
#(
  parameter int AW = 16,
  parameter int DW = 32,
  parameter int Y = 4,
  parameter int SLICE = 1024,
  parameter int RD_LAT = 2
) (
  input logic clk,
  input logic rst,
  output_fm_multibank_if.master bus
);
  localparam int BW = bank_w(Y);
  state_t state_q, state_d;
  logic [AW-1:0] addr_q, addr_d, wr_addr_q, wr_addr_d;
  logic [BW-1:0] bank_q, bank_d, wr_bank_q, wr_bank_d, pbank;
  logic [DW-1:0] wr_data_q, wr_data_d;
  logic wr_vld_q, wr_vld_d, fin_q, fin_d, zero_q, zero_d;
  logic wrap, last, ld_act, pop, issue, adv, ld_dn, st_dn, push, inflight;
  // fin_q marks that the last load word has been taken; the engine then waits for its write to land
  always_comb begin
    wrap = addr_q == AW'(SLICE - 1);
    last = wrap && bank_q == BW'(Y - 1);
    ld_act = state_q == LOAD && !fin_q;
    pop = ld_act && !zero_q && !bus.ld_fifo_empty;
    issue = state_q == STORE && !bus.st_fifo_almost_full;
    adv = issue || (ld_act && (zero_q || !bus.ld_fifo_empty));
    ld_dn = state_q == LOAD && fin_q && !wr_vld_q;
    st_dn = state_q == DRAIN && !inflight;
    state_d = state_q;
    addr_d = adv ? (wrap ? '0 : addr_q + 1'b1) : addr_q;
    bank_d = (adv && wrap) ? (last ? '0 : bank_q + 1'b1) : bank_q;
    fin_d = fin_q || (ld_act && adv && last);
    zero_d = zero_q;
    wr_vld_d = ld_act && adv;
    wr_addr_d = addr_q;
    wr_bank_d = bank_q;
    wr_data_d = zero_q ? '0 : bus.ld_fifo_data;
    if (state_q == IDLE && (bus.ld_start || bus.st_start)) begin
      state_d = bus.ld_start ? LOAD : STORE;
      addr_d = '0;
      bank_d = '0;
      fin_d = 1'b0;
`ifdef OUTPUT_FM_ZERO_INIT_EN
      zero_d = bus.ld_start && bus.zero_init;
`else
      zero_d = 1'b0;
`endif
    end
    if (issue && last) state_d = DRAIN;
    if (ld_dn || st_dn) state_d = IDLE;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      addr_q <= '0;
      bank_q <= '0;
      wr_addr_q <= '0;
      wr_bank_q <= '0;
      wr_data_q <= '0;
      wr_vld_q <= 1'b0;
      fin_q <= 1'b0;
      zero_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q <= addr_d;
      bank_q <= bank_d;
      wr_addr_q <= wr_addr_d;
      wr_bank_q <= wr_bank_d;
      wr_data_q <= wr_data_d;
      wr_vld_q <= wr_vld_d;
      fin_q <= fin_d;
      zero_q <= zero_d;
    end
  out_fm_rd_pipe #(.RD_LAT(RD_LAT), .BW(BW)) u_rd_pipe (
    .clk(clk), .rst(rst), .vld_i(issue), .bank_i(bank_q),
    .vld_o(push), .bank_o(pbank), .inflight(inflight)
  );
  assign bus.busy = state_q != IDLE;
  assign bus.ld_done = ld_dn;
  assign bus.st_done = st_dn;
  assign bus.ld_fifo_pop = pop;
  assign bus.bank_wr_ena = wr_vld_q ? Y'(1) << wr_bank_q : '0;
  assign bus.bank_wr_addr = wr_vld_q ? wr_addr_q : '0;
  assign bus.bank_wr_data = wr_vld_q ? wr_data_q : '0;
  assign bus.bank_rd_ena = issue ? Y'(1) << bank_q : '0;
  assign bus.bank_rd_addr = issue ? addr_q : '0;
  assign bus.st_fifo_push = push;
  assign bus.st_fifo_data = push ? bus.bank_rd_data[pbank*DW +: DW] : '0;
endmodule

// File: doc/output_fm_multibank.md
OUTPUT_FM_MULTIBANK -- requirements
Module: output_fm_multibank

Interface
REQ-001 SHALL have parameter AW, default 16: bank address width.
REQ-002 SHALL have parameter DW, default 32: data width.
REQ-003 SHALL have parameter Y, default 4: number of out_fm banks, range 1..16.
REQ-004 SHALL have parameter SLICE, default 1024: words per bank slice (Tr*Tc), range 1..2^AW.
REQ-005 SHALL have parameter RD_LAT, default 2: bank read latency in cycles, range 1..4.
REQ-006 SHALL have ports, one per line:
- clk  in  1  sole clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- ld_start  in  1  pulse; starts a load of Y*SLICE words.
- st_start  in  1  pulse; starts a store of Y*SLICE words.
- zero_init  in  1  sampled with ld_start; selects zero fill instead of FIFO load.
- busy  out  1  high while not IDLE.
- ld_done  out  1  one-cycle pulse at load completion.
- st_done  out  1  one-cycle pulse at store completion.
- ld_fifo_data  in  DW  load FIFO head.
- ld_fifo_empty  in  1  load FIFO empty.
- ld_fifo_pop  out  1  load FIFO pop.
- st_fifo_data  out  DW  store FIFO write data.
- st_fifo_push  out  1  store FIFO push.
- st_fifo_almost_full  in  1  store FIFO almost full.
- bank_wr_ena  out  Y  per-bank write strobe, one-hot or zero.
- bank_wr_addr  out  AW  shared write address.
- bank_wr_data  out  DW  shared write data.
- bank_rd_ena  out  Y  per-bank read strobe, one-hot or zero.
- bank_rd_addr  out  AW  shared read address.
- bank_rd_data  in  Y*DW  bank read data; bank k occupies bits [k*DW +: DW].

Function
REQ-007 SHALL implement the FSM states IDLE, LOAD, STORE and DRAIN.
REQ-008 IDLE SHALL go to LOAD on ld_start and to STORE on st_start; if both are asserted together, LOAD SHALL win and st_start SHALL be dropped.
REQ-009 ld_start and st_start SHALL be ignored outside IDLE.
REQ-010 SHALL keep an address counter (0..SLICE-1) and a bank index (0..Y-1), both cleared on entry to LOAD or STORE; the address counter wrapping from SLICE-1 to 0 SHALL advance the bank index.
REQ-011 In LOAD, ld_fifo_pop SHALL equal !ld_fifo_empty.
REQ-012 Each pop SHALL cause, one cycle later, bank_wr_ena[bank]=1 with bank_wr_data equal to the registered FIFO data and bank_wr_addr equal to the registered address.
REQ-013 In STORE, a read SHALL issue (bank_rd_ena[bank]=1) each cycle that st_fifo_almost_full==0.
REQ-014 st_fifo_push SHALL assert exactly RD_LAT cycles after each read issue, with st_fifo_data muxed from the bank issued on that read, using a bank index delayed by RD_LAT.
REQ-015 After the last issue (word Y*SLICE-1), STORE SHALL go to DRAIN; DRAIN SHALL wait until no push is in flight, then pulse st_done and return to IDLE.
REQ-016 The final LOAD write SHALL be followed, in the next cycle, by an ld_done pulse and a return to IDLE.
REQ-017 Reads SHALL not issue while st_fifo_almost_full=1; in-flight pushes SHALL still complete.
REQ-018 bank_wr_ena and bank_rd_ena SHALL never be asserted in the same cycle.

Reset
REQ-019 rst SHALL force IDLE, clear all counters and the delay pipeline, and drive every output to 0 asynchronously.
REQ-020 rst asserted mid-operation SHALL abort the operation with no done pulse.

Configuration
REQ-021 With OUTPUT_FM_ZERO_INIT_EN defined, LOAD with zero_init=1 SHALL write 0 to every address of every bank, one word per cycle, with ld_fifo_pop=0.
REQ-022 Without OUTPUT_FM_ZERO_INIT_EN, zero_init SHALL be ignored and LOAD SHALL always read the FIFO.

Structure
REQ-023 The FSM state enum and the bank-index width constant (clog2 of Y) SHALL be placed in the shared package output_fm_pkg.
REQ-024 The RD_LAT valid/bank-index delay line SHALL be a single sub-module, out_fm_rd_pipe.

Verification
REQ-025 SHALL cover: Y=4, SLICE=8, FIFO never empty, ld_start -> 32 writes in order (bank 0 addr 0..7, then bank 1..3), ld_done 34 cycles after start.
REQ-026 SHALL cover: store with RD_LAT=2 and almost_full low -> 32 pushes, data matching the loaded pattern, st_done after the last push.
REQ-027 SHALL cover: almost_full held high for 5 cycles mid-store -> no reads during the stall, no lost or duplicate words, total of 32 pushes.
REQ-028 SHALL cover: ld_start and st_start in the same cycle -> LOAD only; st_start during LOAD -> ignored.
REQ-029 SHALL cover: rst pulsed at word 10 of a load -> all outputs 0, state IDLE, no ld_done.
REQ-030 SHALL cover: with OUTPUT_FM_ZERO_INIT_EN, ld_start with zero_init=1 -> 32 zero writes, ld_fifo_pop never asserted.
